// File: rtl/mips_multicycle_ctrl_pkg.sv
// rtl/mips_multicycle_ctrl_pkg.sv - state, opcode and control encodings for the multicycle controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRC_B_RT     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       retire;
    } ctrl_t;

    // Pure per-state control word; handshake-qualified strobes are added by the top.
    function automatic ctrl_t ctrl_for(input state_t s, input logic bne);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PC_SRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRC_B_IMM_SH;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_RT;
                c.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.retire    = 1'b1;
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_ITYPE;
            end
            S_I_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRC_B_RT;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PC_SRC_ALUOUT;
                c.branch_ne     = bne;
                c.retire        = 1'b1;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PC_SRC_JUMP;
                c.retire   = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_watchdog.sv
// rtl/mips_multicycle_ctrl_watchdog.sv - memory handshake timeout counter
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 255,
    parameter bit TIMEOUT_EN  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    // Value held after MEM_TIMEOUT-1 waiting cycles; the next waiting cycle is the last allowed.
    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count;

    // Count waiting cycles; restart whenever no access is pending or one completes.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // A ready in the final cycle deasserts enable, so a completing access always wins.
    assign expired = TIMEOUT_EN && enable && (count == LAST);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with shared-memory handshake
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter bit TIMEOUT_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [5:0] opCode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       bus_error,
    output logic       retired,
    output logic [3:0] state_o
);
    import mips_ctrl_pkg::*;

    state_t state, next_state;
    ctrl_t  ctrl_q;
    logic   illegal_d, timeout_d, illegal_q, bus_error_q;
    logic   in_mem, wd_clear, wd_enable, expired;
    state_t after_retire;

    // funct belongs to the ALU decoder and zero to the PC-load gate; neither steers sequencing.
    logic unused_inputs;
    assign unused_inputs = ^{funct, zero};

    assign in_mem       = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign wd_enable    = in_mem && !mem_ready;
    assign wd_clear     = !in_mem || mem_ready;
    assign after_retire = run ? S_FETCH : S_IDLE;

    mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TIMEOUT_EN (TIMEOUT_EN)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(expired)
    );

    // Next-state selection; run is only looked at in IDLE and on retirement.
    always_comb begin
        next_state = state;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;
        case (state)
            S_IDLE:     if (run) next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else if (expired) begin
                    next_state = S_IDLE;
                    timeout_d  = 1'b1;
                end
            end
            S_DECODE: begin
                case (opCode)
                    OP_RTYPE:                         next_state = S_R_EXEC;
                    OP_LW, OP_SW:                     next_state = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_I_EXEC;
                    OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
                    OP_J:                             next_state = S_JUMP;
                    default: begin
                        next_state = S_FETCH;
                        illegal_d  = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: next_state = (opCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) begin
                    next_state = S_MEM_WB;
                end else if (expired) begin
                    next_state = S_IDLE;
                    timeout_d  = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    next_state = after_retire;
                end else if (expired) begin
                    next_state = S_IDLE;
                    timeout_d  = 1'b1;
                end
            end
            S_R_EXEC:   next_state = S_R_WB;
            S_I_EXEC:   next_state = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: next_state = after_retire;
            default:    next_state = S_IDLE;
        endcase
    end

    // State register with the control word registered alongside it from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state       <= next_state;
            ctrl_q      <= ctrl_for(next_state, opCode[0]);
            illegal_q   <= illegal_d;
            bus_error_q <= timeout_d;
        end
    end

    assign mem_req       = ctrl_q.mem_req;
    assign mem_write     = ctrl_q.mem_write;
    assign i_or_d        = ctrl_q.i_or_d;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign branch_ne     = ctrl_q.branch_ne;
    assign pc_src        = ctrl_q.pc_src;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign illegal_op    = illegal_q;
    assign bus_error     = bus_error_q;
    assign state_o       = state;

    // Fetch strobes and store completion fire only in the cycle memory accepts the access.
    assign ir_write = (state == S_FETCH) && mem_ready;
    assign pc_write = ctrl_q.pc_write || ir_write;
    assign retired  = ctrl_q.retire || ((state == S_MEM_WR) && mem_ready);

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM for the MIPS datapath. It takes opCode/funct from the instruction field splitter and sequences fetch, decode, execute, memory and writeback over several cycles. It drives every datapath mux, enable and ALU-op control, and talks to a single shared instruction/data memory through a req/ready handshake with a watchdog timeout.

Parameters:
MEM_TIMEOUT, 255, max cycles mem_req may stay high without mem_ready before bus_error; 8-bit counter.
TIMEOUT_EN, 1, 0 disables the watchdog (wait forever).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
run  in  1  level; allows leaving IDLE
opCode  in  6  instruction[31:26] from splitter (valid once IR loaded)
funct  in  6  instruction[5:0] from splitter
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
mem_write  out  1  1=store, 0=read (valid with mem_req)
i_or_d  out  1  0=PC address, 1=ALUOut address
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  conditional PC load (branch)
branch_ne  out  1  0=beq (load if zero), 1=bne (load if !zero)
pc_src  out  2  00=ALU, 01=ALUOut, 10=jump target
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct-decoded, 11=opcode-decoded I-type
reg_write  out  1  register-file write enable
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
illegal_op  out  1  one-cycle pulse on an unsupported opcode
bus_error  out  1  one-cycle pulse on memory timeout
retired  out  1  one-cycle pulse on final cycle of each completed instruction
state_o  out  4  current state encoding (debug)

Behaviour:
- Moore outputs decoded from the state register. Pulses illegal_op, bus_error and retired are registered.
- Reset (synchronous): state=IDLE, watchdog=0, all outputs 0. reset overrides everything, including mid-handshake; memory must drop an in-flight request when mem_req falls.
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- IDLE: all outputs 0. Goes to FETCH when run=1.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write are asserted only in the cycle mem_ready=1, then go to DECODE. Otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opCode:
  - 000000 -> R_EXEC
  - 100011, 101011 -> MEM_ADDR
  - 001000, 001100, 001101, 001010 -> I_EXEC
  - 000100, 000101 -> BRANCH
  - 000010 -> JUMP
  - anything else -> illegal_op pulse, go to FETCH (PC already advanced; no retire).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, i_or_d=1, mem_write=0. On mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, retired. Go to FETCH, or IDLE if run=0.
- MEM_WR: mem_req=1, mem_write=1, i_or_d=1. On mem_ready: retired, go to FETCH/IDLE.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retired. funct is not checked here; the ALU decoder owns it.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. Go to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retired.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, branch_ne=opCode[0], retired.
- JUMP: pc_write=1, pc_src=10, retired.
- Every retiring state goes to FETCH when run=1, otherwise to IDLE. run is sampled only at retirement and in IDLE.
- Watchdog: clears on entering any mem_req state and counts each cycle while mem_req=1 && !mem_ready. mem_ready wins on the same cycle the count reaches MEM_TIMEOUT. If it reaches MEM_TIMEOUT first (and TIMEOUT_EN=1): bus_error pulse, mem_req drops, go to IDLE. No ir_write/pc_write/reg_write occur on that path.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J
  - alu_op, alu_src_b and pc_src encodings
- One sub-module, mem_watchdog: counter, clear/enable inputs, expired output.

Test Plan:
- reset=1 for 2 cycles, run=1, mem_ready=0 -> all outputs 0 in IDLE, then FETCH with mem_req=1, i_or_d=0.
- R-type (opCode=000000), mem_ready=1 in first FETCH cycle -> FETCH, DECODE, R_EXEC, R_WB. R_WB has reg_write=1, reg_dst=1 and retired; 4 cycles per instruction.
- lw (100011) with mem_ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles, then MEM_WB with mem_to_reg=1, reg_write=1. sw (101011): no reg_write.
- bne (000101) -> BRANCH with pc_write_cond=1, branch_ne=1, pc_src=01. j (000010) -> JUMP with pc_write=1, pc_src=10.
- opCode=111111 -> illegal_op single pulse leaving DECODE, next state FETCH, no retired.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_error pulse after 4 waiting cycles, state IDLE, ir_write never 1. Reset asserted mid-MEM_WR -> next cycle IDLE, mem_req=0.
